// File: rtl/mac_arbiter_if.sv
// Client request/operand/result signals plus the shared-MAC port of the two-client
// MAC arbiter. The master side is the clients and the external MAC together.
interface mac_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 19,
    parameter int LEN_W  = 4
);
    logic                     req0;
    logic                     req1;
    logic        [LEN_W-1:0]  len0;
    logic        [LEN_W-1:0]  len1;
    logic signed [DATA_W-1:0] a0;
    logic signed [DATA_W-1:0] b0;
    logic signed [DATA_W-1:0] a1;
    logic signed [DATA_W-1:0] b1;
    logic                     gnt0;
    logic                     gnt1;
    logic                     ack0;
    logic                     ack1;
    logic                     rdy0;
    logic                     rdy1;
    logic signed [ACC_W-1:0]  result;
    logic signed [DATA_W-1:0] mac_a;
    logic signed [DATA_W-1:0] mac_b;
    logic                     mac_clr;
    logic signed [ACC_W-1:0]  mac_out;
    logic                     busy;

    modport slave (
        input  req0, req1, len0, len1, a0, b0, a1, b1, mac_out,
        output gnt0, gnt1, ack0, ack1, rdy0, rdy1, result, mac_a, mac_b, mac_clr, busy
    );

    modport master (
        output req0, req1, len0, len1, a0, b0, a1, b1, mac_out,
        input  gnt0, gnt1, ack0, ack1, rdy0, rdy1, result, mac_a, mac_b, mac_clr, busy
    );
endinterface

// File: rtl/mac_arbiter.sv
// Round-robin arbiter sharing one external multiply-accumulate unit between two
// clients, each requesting a signed dot product of up to 2**LEN_W-1 beats.
module mac_arbiter #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 19,
    parameter int LEN_W  = 4
) (
    input  logic         clk,
    input  logic         reset,
    mac_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  r_state;
    logic                    r_id;
    logic                    r_lastServed;
    logic [LEN_W-1:0]        r_count;
    logic                    r_gnt0;
    logic                    r_gnt1;
    logic                    r_ack0;
    logic                    r_ack1;
    logic                    r_rdy0;
    logic                    r_rdy1;
    logic                    r_clr;
    logic                    r_busy;
    logic signed [ACC_W-1:0] r_result;

    logic                     w_anyReq;
    logic                     w_pick;
    logic signed [DATA_W-1:0] w_macA;
    logic signed [DATA_W-1:0] w_macB;

    assign w_anyReq = bus.req0 | bus.req1;
    // With both clients requesting, the one not served last wins.
    assign w_pick   = (bus.req0 & bus.req1) ? ~r_lastServed : bus.req1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_id         <= 1'b0;
            r_lastServed <= 1'b1;
            r_count      <= '0;
            r_gnt0       <= 1'b0;
            r_gnt1       <= 1'b0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_rdy0       <= 1'b0;
            r_rdy1       <= 1'b0;
            r_clr        <= 1'b0;
            r_busy       <= 1'b0;
            r_result     <= '0;
        end else begin
            r_rdy0 <= 1'b0;
            r_rdy1 <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_anyReq) begin
                        r_id    <= w_pick;
                        r_count <= w_pick ? bus.len1 : bus.len0;
                        r_gnt0  <= ~w_pick;
                        r_gnt1  <= w_pick;
                        r_clr   <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= CLEAR;
                    end
                end
                CLEAR: begin
                    r_clr <= 1'b0;
                    if (r_count != '0) begin
                        r_ack0  <= ~r_id;
                        r_ack1  <= r_id;
                        r_state <= RUN;
                    end else begin
                        r_state <= DONE;
                    end
                end
                RUN: begin
                    r_count <= r_count - LEN_W'(1);
                    if (r_count == LEN_W'(1)) begin
                        r_ack0  <= 1'b0;
                        r_ack1  <= 1'b0;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    // The MAC has absorbed the last beat by now, so its output is the full sum.
                    r_result     <= bus.mac_out;
                    r_rdy0       <= ~r_id;
                    r_rdy1       <= r_id;
                    r_lastServed <= r_id;
                    r_gnt0       <= 1'b0;
                    r_gnt1       <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Operands pass straight through so each beat reaches the MAC in the cycle it is acked.
    assign w_macA = r_ack0 ? bus.a0 : (r_ack1 ? bus.a1 : '0);
    assign w_macB = r_ack0 ? bus.b0 : (r_ack1 ? bus.b1 : '0);

    assign bus.mac_a   = w_macA;
    assign bus.mac_b   = w_macB;
    assign bus.mac_clr = r_clr;
    assign bus.gnt0    = r_gnt0;
    assign bus.gnt1    = r_gnt1;
    assign bus.ack0    = r_ack0;
    assign bus.ack1    = r_ack1;
    assign bus.rdy0    = r_rdy0;
    assign bus.rdy1    = r_rdy1;
    assign bus.result  = r_result;
    assign bus.busy    = r_busy;
endmodule

// File: tb/tb_mac_arbiter.sv
// Self-checking bench for mac_arbiter: directed scenarios plus randomized two-client
// traffic checked against a job-level timing and dot-product model.
`timescale 1ns/1ps
module tb_mac_arbiter;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 19;
    localparam int LEN_W  = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mac_arbiter_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) bif ();

    mac_arbiter #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    // External MAC: clears or accumulates the product of the presented operands.
    always_ff @(posedge clk) begin
        if (reset)
            bif.mac_out <= '0;
        else if (bif.mac_clr)
            bif.mac_out <= '0;
        else
            bif.mac_out <= bif.mac_out + ACC_W'(bif.mac_a) * ACC_W'(bif.mac_b);
    end

    int passCount;
    int checkCount;
    int cyc;

    logic [1:0] reqOn;
    logic [1:0] reqMask;
    logic [1:0] pendAdv;
    int         lenV[2];
    int         idx[2];
    int         jobsLeft[2];
    int         opA[2][16];
    int         opB[2][16];
    int         lenMin;
    int         lenMax;

    logic [1:0]               sGnt;
    logic [1:0]               sAck;
    logic [1:0]               sRdy;
    logic                     sClr;
    logic                     sBusy;
    logic signed [ACC_W-1:0]  sResult;
    logic signed [DATA_W-1:0] sMacA;
    logic signed [DATA_W-1:0] sMacB;

    function automatic int job_sum(input int c);
        int s = 0;
        for (int k = 0; k < lenV[c]; k++) s += opA[c][k] * opB[c][k];
        return s;
    endfunction

    task automatic new_job(input int c, input int len);
        lenV[c] = len;
        for (int k = 0; k < 16; k++) begin
            opA[c][k] = int'($urandom_range(255)) - 128;
            opB[c][k] = int'($urandom_range(255)) - 128;
        end
        idx[c]     = 0;
        pendAdv[c] = 1'b0;
    endtask

    task automatic drive();
        bif.req0 = reqOn[0] & ~reqMask[0];
        bif.req1 = reqOn[1] & ~reqMask[1];
        if (reqOn[0]) begin
            bif.len0 = LEN_W'(lenV[0]);
            bif.a0   = DATA_W'(opA[0][idx[0]]);
            bif.b0   = DATA_W'(opB[0][idx[0]]);
        end else begin
            bif.len0 = LEN_W'($urandom);
            bif.a0   = DATA_W'($urandom);
            bif.b0   = DATA_W'($urandom);
        end
        if (reqOn[1]) begin
            bif.len1 = LEN_W'(lenV[1]);
            bif.a1   = DATA_W'(opA[1][idx[1]]);
            bif.b1   = DATA_W'(opB[1][idx[1]]);
        end else begin
            bif.len1 = LEN_W'($urandom);
            bif.a1   = DATA_W'($urandom);
            bif.b1   = DATA_W'($urandom);
        end
    endtask

    // One cycle of the two client models: sample outputs, advance on ack, drop or renew on rdy.
    task automatic step_cycle();
        @(negedge clk);
        cyc++;
        sGnt    = {bif.gnt1, bif.gnt0};
        sAck    = {bif.ack1, bif.ack0};
        sRdy    = {bif.rdy1, bif.rdy0};
        sClr    = bif.mac_clr;
        sBusy   = bif.busy;
        sResult = bif.result;
        for (int c = 0; c < 2; c++) begin
            if (pendAdv[c] && idx[c] < 15) idx[c]++;
            pendAdv[c] = sAck[c];
            if (sRdy[c] && reqOn[c]) begin
                if (jobsLeft[c] > 0) begin
                    jobsLeft[c]--;
                    new_job(c, int'($urandom_range(lenMax, lenMin)));
                end else begin
                    reqOn[c] = 1'b0;
                end
            end
        end
        drive();
        #1;
        sMacA = bif.mac_a;
        sMacB = bif.mac_b;
    endtask

    task automatic do_reset();
        reqOn   = 2'b00;
        reqMask = 2'b00;
        pendAdv = 2'b00;
        for (int c = 0; c < 2; c++) begin
            idx[c]      = 0;
            jobsLeft[c] = 0;
        end
        reset = 1'b1;
        repeat (2) step_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checkCount++; if (sGnt !== 2'b00) $display("[TB] FAIL reset_gnt: got %b expected 00", sGnt); else passCount++;
        checkCount++; if (sAck !== 2'b00) $display("[TB] FAIL reset_ack: got %b expected 00", sAck); else passCount++;
        checkCount++; if (sRdy !== 2'b00) $display("[TB] FAIL reset_rdy: got %b expected 00", sRdy); else passCount++;
        checkCount++; if (sBusy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", sBusy); else passCount++;
        checkCount++; if (sClr !== 1'b0) $display("[TB] FAIL reset_clr: got %b expected 0", sClr); else passCount++;
        checkCount++; if (sResult !== '0) $display("[TB] FAIL reset_result: got %0d expected 0", sResult); else passCount++;
        checkCount++; if (sMacA !== '0) $display("[TB] FAIL reset_mac_a: got %0d expected 0", sMacA); else passCount++;
        checkCount++; if (sMacB !== '0) $display("[TB] FAIL reset_mac_b: got %0d expected 0", sMacB); else passCount++;
        step_cycle();
        checkCount++; if (sBusy !== 1'b0) $display("[TB] FAIL idle_busy: got %b expected 0", sBusy); else passCount++;
    endtask

    task automatic test_single_job();
        int t;
        int acks;
        int gntCycles;
        int otherSeen;
        int rdyAt;
        logic signed [ACC_W-1:0] res;
        do_reset();
        new_job(0, 3);
        opA[0][0] = 2;  opB[0][0] = 3;
        opA[0][1] = -4; opB[0][1] = 5;
        opA[0][2] = 7;  opB[0][2] = 7;
        reqOn[0] = 1'b1;
        step_cycle();
        t = cyc; acks = 0; gntCycles = 0; otherSeen = 0; rdyAt = -1; res = 'x;
        for (int n = 0; n < 9; n++) begin
            step_cycle();
            if (sAck[0]) acks++;
            if (sGnt[0]) gntCycles++;
            if (sGnt[1] || sAck[1] || sRdy[1]) otherSeen++;
            if (sRdy[0] && rdyAt < 0) begin rdyAt = cyc - t; res = sResult; end
        end
        checkCount++; if (acks != 3) $display("[TB] FAIL single_ack_count: got %0d expected 3", acks); else passCount++;
        checkCount++; if (gntCycles != 5) $display("[TB] FAIL single_gnt_cycles: got %0d expected 5", gntCycles); else passCount++;
        checkCount++; if (rdyAt != 6) $display("[TB] FAIL single_rdy_latency: got %0d expected 6", rdyAt); else passCount++;
        checkCount++; if (res !== ACC_W'(35)) $display("[TB] FAIL single_result: got %0d expected 35", res); else passCount++;
        checkCount++; if (otherSeen != 0) $display("[TB] FAIL single_client1_quiet: got %0d cycles expected 0", otherSeen); else passCount++;
    endtask

    task automatic test_round_robin();
        int order[$];
        int expSum[2];
        logic [1:0] prevGnt;
        int rdyCount;
        int overlap;
        int w;
        do_reset();
        lenMin = 2; lenMax = 2;
        for (int c = 0; c < 2; c++) begin
            new_job(c, 2);
            jobsLeft[c] = 2;
        end
        reqOn = 2'b11;
        prevGnt = 2'b00; rdyCount = 0; overlap = 0;
        for (int n = 0; n < 80 && rdyCount < 6; n++) begin
            step_cycle();
            if (sGnt == 2'b11) overlap++;
            if (prevGnt == 2'b00 && sGnt != 2'b00) begin
                w = sGnt[1] ? 1 : 0;
                order.push_back(w);
                expSum[w] = job_sum(w);
            end
            for (int c = 0; c < 2; c++) begin
                if (sRdy[c]) begin
                    rdyCount++;
                    checkCount++;
                    if (sResult !== ACC_W'(expSum[c]))
                        $display("[TB] FAIL rr_result_client%0d: got %0d expected %0d", c, sResult, expSum[c]);
                    else passCount++;
                end
            end
            prevGnt = sGnt;
        end
        checkCount++; if (overlap != 0) $display("[TB] FAIL rr_overlap: got %0d cycles expected 0", overlap); else passCount++;
        checkCount++; if (order.size() != 6) $display("[TB] FAIL rr_job_count: got %0d expected 6", order.size()); else passCount++;
        for (int i = 0; i < order.size(); i++) begin
            checkCount++;
            if (order[i] != i % 2) $display("[TB] FAIL rr_order_%0d: got client %0d expected %0d", i, order[i], i % 2);
            else passCount++;
        end
        lenMin = 0; lenMax = 15;
    endtask

    task automatic test_len_zero();
        int t;
        int acks;
        int rdyAt;
        logic signed [ACC_W-1:0] res;
        do_reset();
        new_job(0, 1);
        opA[0][0] = 5; opB[0][0] = 5;
        reqOn[0] = 1'b1;
        for (int n = 0; n < 10 && !sRdy[0]; n++) step_cycle();
        checkCount++; if (sResult !== ACC_W'(25)) $display("[TB] FAIL zero_prior_result: got %0d expected 25", sResult); else passCount++;
        new_job(1, 0);
        reqOn[1] = 1'b1;
        step_cycle();
        t = cyc; acks = 0; rdyAt = -1; res = 'x;
        for (int n = 0; n < 6; n++) begin
            step_cycle();
            if (sAck[1]) acks++;
            if (sRdy[1] && rdyAt < 0) begin rdyAt = cyc - t; res = sResult; end
        end
        checkCount++; if (acks != 0) $display("[TB] FAIL zero_ack_count: got %0d expected 0", acks); else passCount++;
        checkCount++; if (rdyAt != 3) $display("[TB] FAIL zero_rdy_latency: got %0d expected 3", rdyAt); else passCount++;
        checkCount++; if (res !== '0) $display("[TB] FAIL zero_result: got %0d expected 0", res); else passCount++;
    endtask

    task automatic test_max_len();
        int t;
        int acks;
        int rdyAt;
        logic signed [ACC_W-1:0] res;
        do_reset();
        new_job(0, 15);
        for (int k = 0; k < 16; k++) begin opA[0][k] = -128; opB[0][k] = -128; end
        reqOn[0] = 1'b1;
        step_cycle();
        t = cyc; acks = 0; rdyAt = -1; res = 'x;
        for (int n = 0; n < 22; n++) begin
            step_cycle();
            if (sAck[0]) acks++;
            if (sRdy[0] && rdyAt < 0) begin rdyAt = cyc - t; res = sResult; end
        end
        checkCount++; if (acks != 15) $display("[TB] FAIL max_ack_count: got %0d expected 15", acks); else passCount++;
        checkCount++; if (rdyAt != 18) $display("[TB] FAIL max_rdy_latency: got %0d expected 18", rdyAt); else passCount++;
        checkCount++; if (res !== ACC_W'(245760)) $display("[TB] FAIL max_result: got %0d expected 245760", res); else passCount++;
    endtask

    task automatic test_req_drop();
        int t;
        int acks;
        int rdyAt;
        int expSum;
        logic signed [ACC_W-1:0] res;
        do_reset();
        new_job(0, 4);
        expSum = job_sum(0);
        reqOn[0] = 1'b1;
        step_cycle();
        t = cyc; acks = 0; rdyAt = -1; res = 'x;
        for (int n = 0; n < 10; n++) begin
            step_cycle();
            if (sAck[0]) acks++;
            if (acks == 2) reqMask[0] = 1'b1;
            if (sRdy[0] && rdyAt < 0) begin rdyAt = cyc - t; res = sResult; end
        end
        reqMask = 2'b00;
        checkCount++; if (acks != 4) $display("[TB] FAIL drop_ack_count: got %0d expected 4", acks); else passCount++;
        checkCount++; if (rdyAt != 7) $display("[TB] FAIL drop_rdy_latency: got %0d expected 7", rdyAt); else passCount++;
        checkCount++; if (res !== ACC_W'(expSum)) $display("[TB] FAIL drop_result: got %0d expected %0d", res, expSum); else passCount++;
    endtask

    task automatic test_mid_job_reset();
        int t;
        int acks;
        int rdySeen;
        int rdyAt;
        logic signed [ACC_W-1:0] res;
        do_reset();
        new_job(0, 1);
        opA[0][0] = 5; opB[0][0] = 5;
        reqOn[0] = 1'b1;
        for (int n = 0; n < 10 && !sRdy[0]; n++) step_cycle();
        new_job(1, 6);
        reqOn[1] = 1'b1;
        acks = 0;
        for (int n = 0; n < 10 && acks < 3; n++) begin
            step_cycle();
            if (sAck[1]) acks++;
        end
        checkCount++; if (acks != 3) $display("[TB] FAIL midrst_reached_run: got %0d acks expected 3", acks); else passCount++;
        reset = 1'b1;
        reqOn = 2'b00; pendAdv = 2'b00; idx[1] = 0;
        step_cycle();
        reset = 1'b0;
        checkCount++; if (sGnt !== 2'b00) $display("[TB] FAIL midrst_gnt: got %b expected 00", sGnt); else passCount++;
        checkCount++; if (sAck !== 2'b00) $display("[TB] FAIL midrst_ack: got %b expected 00", sAck); else passCount++;
        checkCount++; if (sRdy !== 2'b00) $display("[TB] FAIL midrst_rdy: got %b expected 00", sRdy); else passCount++;
        checkCount++; if (sBusy !== 1'b0) $display("[TB] FAIL midrst_busy: got %b expected 0", sBusy); else passCount++;
        checkCount++; if (sClr !== 1'b0) $display("[TB] FAIL midrst_clr: got %b expected 0", sClr); else passCount++;
        checkCount++; if (sResult !== '0) $display("[TB] FAIL midrst_result: got %0d expected 0", sResult); else passCount++;
        checkCount++; if (sMacA !== '0 || sMacB !== '0) $display("[TB] FAIL midrst_mac_ops: got %0d,%0d expected 0,0", sMacA, sMacB); else passCount++;
        rdySeen = 0;
        for (int n = 0; n < 8; n++) begin
            step_cycle();
            if (sRdy != 2'b00) rdySeen++;
        end
        checkCount++; if (rdySeen != 0) $display("[TB] FAIL midrst_no_rdy: got %0d pulses expected 0", rdySeen); else passCount++;
        new_job(1, 2);
        opA[1][0] = 3;  opB[1][0] = -2;
        opA[1][1] = 10; opB[1][1] = 4;
        reqOn[1] = 1'b1;
        step_cycle();
        t = cyc; rdyAt = -1; res = 'x;
        for (int n = 0; n < 8; n++) begin
            step_cycle();
            if (sRdy[1] && rdyAt < 0) begin rdyAt = cyc - t; res = sResult; end
        end
        checkCount++; if (rdyAt != 5) $display("[TB] FAIL midrst_after_latency: got %0d expected 5", rdyAt); else passCount++;
        checkCount++; if (res !== ACC_W'(34)) $display("[TB] FAIL midrst_after_result: got %0d expected 34", res); else passCount++;
    endtask

    // Job-level model: a grant follows one cycle after any request seen while idle, then
    // CLEAR, len beats, DONE, and a rdy pulse; contention goes to the client not served last.
    task automatic test_random_traffic();
        logic       jobOn;
        int         jobOwner;
        int         jobStart;
        int         jobLen;
        int         jobSum;
        int         lastServed;
        int         k;
        logic [1:0] expGnt;
        logic [1:0] expAck;
        logic [1:0] expRdy;
        logic       expClr;
        logic       expBusy;
        logic signed [DATA_W-1:0] expA;
        logic signed [DATA_W-1:0] expB;
        do_reset();
        lenMin = 0; lenMax = 15;
        jobOn = 1'b0; lastServed = 1; jobOwner = 0; jobStart = 0; jobLen = 0; jobSum = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < 2; c++) begin
                if (!reqOn[c] && $urandom_range(3) == 0) begin
                    new_job(c, int'($urandom_range(15)));
                    jobsLeft[c] = int'($urandom_range(2));
                    reqOn[c] = 1'b1;
                end
            end
            step_cycle();
            expGnt = 2'b00; expAck = 2'b00; expRdy = 2'b00; expClr = 1'b0; expBusy = 1'b0;
            k = cyc - jobStart;
            if (jobOn) begin
                if (k <= jobLen + 1) begin expGnt[jobOwner] = 1'b1; expBusy = 1'b1; end
                if (k >= 1 && k <= jobLen) expAck[jobOwner] = 1'b1;
                if (k == 0) expClr = 1'b1;
                if (k == jobLen + 2) expRdy[jobOwner] = 1'b1;
            end
            checkCount++; if (sGnt !== expGnt) $display("[TB] FAIL rand_gnt @%0d: got %b expected %b", cyc, sGnt, expGnt); else passCount++;
            checkCount++; if (sAck !== expAck) $display("[TB] FAIL rand_ack @%0d: got %b expected %b", cyc, sAck, expAck); else passCount++;
            checkCount++; if (sRdy !== expRdy) $display("[TB] FAIL rand_rdy @%0d: got %b expected %b", cyc, sRdy, expRdy); else passCount++;
            checkCount++; if (sClr !== expClr) $display("[TB] FAIL rand_clr @%0d: got %b expected %b", cyc, sClr, expClr); else passCount++;
            checkCount++; if (sBusy !== expBusy) $display("[TB] FAIL rand_busy @%0d: got %b expected %b", cyc, sBusy, expBusy); else passCount++;
            if (expAck != 2'b00) begin
                expA = DATA_W'(opA[jobOwner][k-1]);
                expB = DATA_W'(opB[jobOwner][k-1]);
            end else begin
                expA = '0;
                expB = '0;
            end
            checkCount++;
            if (sMacA !== expA || sMacB !== expB)
                $display("[TB] FAIL rand_mac_ops @%0d: got %0d,%0d expected %0d,%0d", cyc, sMacA, sMacB, expA, expB);
            else passCount++;
            if (jobOn && k == jobLen + 2) begin
                checkCount++;
                if (sResult !== ACC_W'(jobSum))
                    $display("[TB] FAIL rand_result @%0d: got %0d expected %0d", cyc, sResult, jobSum);
                else passCount++;
                lastServed = jobOwner;
                jobOn = 1'b0;
            end
            if (!jobOn && (reqOn[0] || reqOn[1])) begin
                jobOwner = (reqOn[0] && reqOn[1]) ? 1 - lastServed : (reqOn[1] ? 1 : 0);
                jobStart = cyc + 1;
                jobLen   = lenV[jobOwner];
                jobSum   = job_sum(jobOwner);
                jobOn    = 1'b1;
            end
        end
    endtask

    initial begin
        passCount = 0;
        checkCount = 0;
        cyc = 0;
        reset = 1'b1;
        reqOn = 2'b00;
        reqMask = 2'b00;
        pendAdv = 2'b00;
        lenMin = 0;
        lenMax = 15;
        for (int c = 0; c < 2; c++) begin
            idx[c] = 0;
            jobsLeft[c] = 0;
            new_job(c, 0);
        end
        drive();
        test_reset();
        test_single_job();
        test_round_robin();
        test_len_zero();
        test_max_len();
        test_req_drop();
        test_mid_job_reset();
        test_random_traffic();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
